// File: rtl/gyro_pkg.sv
// Shared definitions for the gyro conditioning path.
//   gyro_state_t : calibrator FSM states (CAL = averaging bias, RUN = correcting)
//   GYRO_WIDTH   : native MPU-6050 rate sample width
//   sat_clamp    : clamp a wide signed value into a signed range of 'width' bits
package gyro_pkg;

  typedef enum logic {
    CAL,
    RUN
  } gyro_state_t;

  localparam int GYRO_WIDTH = 16;

  function automatic logic signed [63:0] sat_clamp(input logic signed [63:0] v,
                                                   input int unsigned        width);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (width - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/gyro_axis_correct.sv
// One axis of the bias calibrator: bias accumulator, bias register and the
// subtract / saturate / deadband correction path.
// Ports:
//   clk_100mhz, rst_in : clock, async active-high reset
//   sample_in          : raw signed rate for this axis
//   accumulate         : add sample into accumulator
//   latch_bias         : final calibration sample; compute bias, clear accumulator
//   clear              : discard accumulator (recalibration start)
//   correct            : register corrected sample
//   corr_out           : corrected sample (held between strobes)
//   bias_out           : current bias
module gyro_axis_correct
  import gyro_pkg::*;
#(
  parameter int WIDTH       = GYRO_WIDTH,
  parameter int SAMPLE_LOG2 = 8,
  parameter int DEADBAND    = 16
) (
  input  logic             clk_100mhz,
  input  logic             rst_in,
  input  logic [WIDTH-1:0] sample_in,
  input  logic             accumulate,
  input  logic             latch_bias,
  input  logic             clear,
  input  logic             correct,
  output logic [WIDTH-1:0] corr_out,
  output logic [WIDTH-1:0] bias_out
);

  localparam int AW = WIDTH + SAMPLE_LOG2;
  localparam logic signed [WIDTH:0] DB = (WIDTH + 1)'(DEADBAND);

  logic signed [AW-1:0]    acc;
  logic signed [AW-1:0]    acc_sum;
  logic signed [AW-1:0]    acc_shift;
  logic signed [WIDTH:0]   diff;
  logic signed [WIDTH-1:0] sat;
  logic signed [WIDTH:0]   sat_ext;
  logic signed [WIDTH:0]   mag;
  logic [WIDTH-1:0]        corr_next;

  always_comb begin
    acc_sum   = acc + {{SAMPLE_LOG2{sample_in[WIDTH-1]}}, sample_in};
    // Arithmetic shift: bias rounds toward -inf.
    acc_shift = acc_sum >>> SAMPLE_LOG2;

    diff      = {sample_in[WIDTH-1], sample_in} - {bias_out[WIDTH-1], bias_out};
    sat       = WIDTH'(sat_clamp(64'(diff), WIDTH));
    sat_ext   = {sat[WIDTH-1], sat};
    mag       = sat_ext[WIDTH] ? -sat_ext : sat_ext;
    corr_next = (mag <= DB) ? '0 : sat;
  end

  always_ff @(posedge clk_100mhz or posedge rst_in) begin
    if (rst_in) begin
      acc      <= '0;
      bias_out <= '0;
      corr_out <= '0;
    end else begin
      if (clear) begin
        acc <= '0;
      end else if (latch_bias) begin
        acc      <= '0;
        bias_out <= acc_shift[WIDTH-1:0];
      end else if (accumulate) begin
        acc <= acc_sum;
      end
      if (correct) begin
        corr_out <= corr_next;
      end
    end
  end

endmodule

// File: rtl/gyro_bias_calibrator.sv
// Zero-rate bias calibrator for MPU-6050 gyro samples.
// Averages 2^SAMPLE_LOG2 stationary samples per axis after reset / recal_in,
// then subtracts the bias, saturates and deadbands each following sample.
// Ports:
//   clk_100mhz, rst_in        : clock, async active-high reset
//   sample_valid_in           : new raw sample strobe on gx_in/gy_in/gz_in
//   recal_in                  : discard bias and recalibrate (beats sample_valid_in)
//   gx_out/gy_out/gz_out      : corrected rates, valid_out strobes 1 cycle after input
//   calibrated_out            : high while a valid bias is in use
//   bias_x_out/_y_out/_z_out  : current biases (debug)
module gyro_bias_calibrator
  import gyro_pkg::*;
#(
  parameter int WIDTH       = GYRO_WIDTH,
  parameter int SAMPLE_LOG2 = 8,
  parameter int DEADBAND    = 16
) (
  input  logic             clk_100mhz,
  input  logic             rst_in,
  input  logic             sample_valid_in,
  input  logic [WIDTH-1:0] gx_in,
  input  logic [WIDTH-1:0] gy_in,
  input  logic [WIDTH-1:0] gz_in,
  input  logic             recal_in,
  output logic [WIDTH-1:0] gx_out,
  output logic [WIDTH-1:0] gy_out,
  output logic [WIDTH-1:0] gz_out,
  output logic             valid_out,
  output logic             calibrated_out,
  output logic [WIDTH-1:0] bias_x_out,
  output logic [WIDTH-1:0] bias_y_out,
  output logic [WIDTH-1:0] bias_z_out
);

  gyro_state_t            state;
  gyro_state_t            state_next;
  logic [SAMPLE_LOG2-1:0] cnt;
  logic                   accumulate;
  logic                   latch_bias;
  logic                   clear;
  logic                   correct;

  always_ff @(posedge clk_100mhz or posedge rst_in) begin
    if (rst_in) begin
      state          <= CAL;
      cnt            <= '0;
      valid_out      <= 1'b0;
      calibrated_out <= 1'b0;
    end else begin
      state          <= state_next;
      valid_out      <= correct;
      calibrated_out <= (state_next == RUN);
      if (clear || latch_bias) begin
        cnt <= '0;
      end else if (accumulate) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  always_comb begin
    state_next = state;
    accumulate = 1'b0;
    latch_bias = 1'b0;
    clear      = 1'b0;
    correct    = 1'b0;
    if (recal_in) begin
      // Recal wins over a coincident sample, which is dropped.
      clear      = 1'b1;
      state_next = CAL;
    end else if (sample_valid_in) begin
      case (state)
        CAL: begin
          if (cnt == '1) begin
            latch_bias = 1'b1;
            state_next = RUN;
          end else begin
            accumulate = 1'b1;
          end
        end
        RUN:     correct = 1'b1;
        default: state_next = CAL;
      endcase
    end
  end

  gyro_axis_correct #(
    .WIDTH(WIDTH), .SAMPLE_LOG2(SAMPLE_LOG2), .DEADBAND(DEADBAND)
  ) u_axis_x (
    .clk_100mhz(clk_100mhz), .rst_in(rst_in), .sample_in(gx_in),
    .accumulate(accumulate), .latch_bias(latch_bias), .clear(clear),
    .correct(correct), .corr_out(gx_out), .bias_out(bias_x_out)
  );

  gyro_axis_correct #(
    .WIDTH(WIDTH), .SAMPLE_LOG2(SAMPLE_LOG2), .DEADBAND(DEADBAND)
  ) u_axis_y (
    .clk_100mhz(clk_100mhz), .rst_in(rst_in), .sample_in(gy_in),
    .accumulate(accumulate), .latch_bias(latch_bias), .clear(clear),
    .correct(correct), .corr_out(gy_out), .bias_out(bias_y_out)
  );

  gyro_axis_correct #(
    .WIDTH(WIDTH), .SAMPLE_LOG2(SAMPLE_LOG2), .DEADBAND(DEADBAND)
  ) u_axis_z (
    .clk_100mhz(clk_100mhz), .rst_in(rst_in), .sample_in(gz_in),
    .accumulate(accumulate), .latch_bias(latch_bias), .clear(clear),
    .correct(correct), .corr_out(gz_out), .bias_out(bias_z_out)
  );

endmodule

// File: tb/tb_gyro_bias_calibrator.sv
module tb_gyro_bias_calibrator;

  localparam int W  = 16;
  localparam int SL = 2;
  localparam int DB = 16;
  localparam int N  = 1 << SL;

  logic                clk_100mhz = 1'b0;
  logic                rst_in = 1'b1;
  logic                sample_valid_in = 1'b0;
  logic                recal_in = 1'b0;
  logic signed [W-1:0] gx_in = '0, gy_in = '0, gz_in = '0;
  logic signed [W-1:0] gx_out, gy_out, gz_out;
  logic                valid_out, calibrated_out;
  logic signed [W-1:0] bias_x_out, bias_y_out, bias_z_out;

  int checks = 0;
  int errors = 0;
  int vcount = 0;

  always #5 clk_100mhz = ~clk_100mhz;

  gyro_bias_calibrator #(.WIDTH(W), .SAMPLE_LOG2(SL), .DEADBAND(DB)) dut (
    .clk_100mhz(clk_100mhz), .rst_in(rst_in), .sample_valid_in(sample_valid_in),
    .gx_in(gx_in), .gy_in(gy_in), .gz_in(gz_in), .recal_in(recal_in),
    .gx_out(gx_out), .gy_out(gy_out), .gz_out(gz_out), .valid_out(valid_out),
    .calibrated_out(calibrated_out), .bias_x_out(bias_x_out),
    .bias_y_out(bias_y_out), .bias_z_out(bias_z_out)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit m_cal;
  int qx[$], qy[$], qz[$];
  int m_bx, m_by, m_bz;
  int e_gx, e_gy, e_gz;
  bit e_valid;

  function automatic int floor_avg(input int q[$]);
    int s, r;
    s = 0;
    foreach (q[i]) s += q[i];
    r = s / N;
    if ((s % N != 0) && s < 0) r = r - 1;
    return r;
  endfunction

  function automatic int correct_val(input int s, input int b);
    int d;
    d = s - b;
    if (d > 32767) d = 32767;
    if (d < -32768) d = -32768;
    if (d <= DB && d >= -DB) d = 0;
    return d;
  endfunction

  always @(posedge clk_100mhz or posedge rst_in) begin
    if (rst_in) begin
      m_cal = 0; qx.delete(); qy.delete(); qz.delete();
      m_bx = 0; m_by = 0; m_bz = 0;
      e_gx = 0; e_gy = 0; e_gz = 0; e_valid = 0;
    end else begin
      e_valid = 0;
      if (recal_in) begin
        m_cal = 0; qx.delete(); qy.delete(); qz.delete();
      end else if (sample_valid_in) begin
        if (!m_cal) begin
          qx.push_back(int'(gx_in)); qy.push_back(int'(gy_in)); qz.push_back(int'(gz_in));
          if (qx.size() == N) begin
            m_bx = floor_avg(qx); m_by = floor_avg(qy); m_bz = floor_avg(qz);
            m_cal = 1;
            qx.delete(); qy.delete(); qz.delete();
          end
        end else begin
          e_gx = correct_val(int'(gx_in), m_bx);
          e_gy = correct_val(int'(gy_in), m_by);
          e_gz = correct_val(int'(gz_in), m_bz);
          e_valid = 1;
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk_100mhz) begin
    if (valid_out) vcount++;
    chk("valid_out", int'(valid_out), int'(e_valid));
    chk("calibrated_out", int'(calibrated_out), int'(m_cal));
    chk("bias_x", int'(bias_x_out), m_bx);
    chk("bias_y", int'(bias_y_out), m_by);
    chk("bias_z", int'(bias_z_out), m_bz);
    chk("gx_out", int'(gx_out), e_gx);
    chk("gy_out", int'(gy_out), e_gy);
    chk("gz_out", int'(gz_out), e_gz);
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input bit sv, input bit rc, input int x, input int y, input int z);
    @(posedge clk_100mhz);
    #2;
    sample_valid_in = sv;
    recal_in        = rc;
    gx_in           = W'(x);
    gy_in           = W'(y);
    gz_in           = W'(z);
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0);
  endtask

  initial begin
    int c0;
    #1;
    chk("reset_calibrated", int'(calibrated_out), 0);
    chk("reset_valid", int'(valid_out), 0);
    chk("reset_bias_x", int'(bias_x_out), 0);
    idle();
    idle();
    rst_in = 1'b0;
    idle();

    // Basic calibration, negative floor, z bias -100
    cyc(1, 0, 10, -1, -100);
    cyc(1, 0, 12, -1, -100);
    cyc(1, 0, 14, -1, -100);
    cyc(1, 0, 16, -2, -100);
    chk("cal_not_yet", int'(calibrated_out), 0);
    idle();
    chk("cal_rise", int'(calibrated_out), 1);
    chk("cal_valid_quiet", int'(valid_out), 0);
    chk("bias_x_13", int'(bias_x_out), 13);
    chk("bias_y_m2", int'(bias_y_out), -2);
    chk("bias_z_m100", int'(bias_z_out), -100);

    // First corrected sample, saturation
    cyc(1, 0, 113, 0, 32767);
    idle();
    chk("first_valid", int'(valid_out), 1);
    chk("gx_100", int'(gx_out), 100);
    chk("gy_deadband", int'(gy_out), 0);
    chk("gz_sat", int'(gz_out), 32767);
    idle();
    chk("valid_single", int'(valid_out), 0);
    chk("gx_hold", int'(gx_out), 100);

    // Deadband edges
    cyc(1, 0, 29, -18, -100);
    idle();
    chk("gx_29_zero", int'(gx_out), 0);
    cyc(1, 0, 30, -19, -117);
    idle();
    chk("gx_30_17", int'(gx_out), 17);
    chk("gy_m19_m17", int'(gy_out), -17);
    chk("gz_m117_m17", int'(gz_out), -17);
    cyc(1, 0, -3, 14, 32767);
    idle();
    chk("gx_m3_zero", int'(gx_out), 0);

    // Recal priority over coincident sample
    cyc(1, 1, 500, 500, 500);
    idle();
    chk("recal_no_valid", int'(valid_out), 0);
    chk("recal_cal_low", int'(calibrated_out), 0);
    chk("recal_old_bias", int'(bias_x_out), 13);
    cyc(1, 0, 20, 0, -8);
    cyc(1, 0, 20, 0, -8);
    idle();
    chk("recal_mid_bias", int'(bias_x_out), 13);
    chk("recal_mid_cal", int'(calibrated_out), 0);
    cyc(1, 0, 20, 0, -8);
    cyc(1, 0, 24, 0, -8);
    idle();
    chk("recal_bias_21", int'(bias_x_out), 21);
    chk("recal_done", int'(calibrated_out), 1);

    // Recal during CAL restarts count
    cyc(0, 1, 0, 0, 0);
    cyc(1, 0, 500, 500, 500);
    cyc(0, 1, 0, 0, 0);
    for (int i = 0; i < N; i++) cyc(1, 0, 8, 8, 8);
    idle();
    chk("recal_in_cal_bias", int'(bias_x_out), 8);

    // Reset mid-calibration
    cyc(0, 1, 0, 0, 0);
    cyc(1, 0, 1000, 1000, 1000);
    cyc(1, 0, 1000, 1000, 1000);
    @(posedge clk_100mhz);
    #2;
    sample_valid_in = 1'b0;
    rst_in = 1'b1;
    #1;
    chk("async_rst_bias", int'(bias_x_out), 0);
    chk("async_rst_cal", int'(calibrated_out), 0);
    idle();
    rst_in = 1'b0;
    for (int i = 0; i < N; i++) cyc(1, 0, 4, 4, 4);
    idle();
    chk("post_rst_bias_x", int'(bias_x_out), 4);
    chk("post_rst_bias_z", int'(bias_z_out), 4);
    chk("post_rst_cal", int'(calibrated_out), 1);

    // Streaming
    c0 = vcount;
    for (int i = 0; i < 20; i++) cyc(1, 0, i * 7 - 50, 1000 - i * 100, i * 3000 - 30000);
    idle();
    idle();
    chk("stream_count", vcount - c0, 20);

    idle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
